// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage types and memory geometry defaults.
package instruction_fetch_pkg;
   localparam int ADDR_WIDTH_DEF = 10;
   localparam int DATA_WIDTH_DEF = 32;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_LAST   = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_e;
endpackage

// File: rtl/instruction_fetch_pc_ctrl.sv
// Fetch PC register, memory address mux and RUN/LAST/HALTED sequencing.
// state  | meaning
// RUN    | fetching sequentially, fetch_pc is the next word to read
// LAST   | LAST_ADDR is being presented to decode; no further fetch
// HALTED | fetch stopped, only redirect or reset restarts it
module fetch_pc_ctrl
   import instruction_fetch_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int LAST_ADDR  = (1 << ADDR_WIDTH_DEF) - 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  redirect_en,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   input  logic [ADDR_WIDTH-1:0] pc_d1,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [ADDR_WIDTH-1:0] fetch_pc,
   output fetch_state_e          state
);
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LAST_ADDR);

   fetch_state_e          r_state;
   fetch_state_e          w_state_nx;
   logic [ADDR_WIDTH-1:0] r_fetch_pc;
   logic [ADDR_WIDTH-1:0] w_fetch_pc_nx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_RUN;
         r_fetch_pc <= '0;
      end else begin
         r_state    <= w_state_nx;
         r_fetch_pc <= w_fetch_pc_nx;
      end
   end

   // Redirect beats stall and every state; stall freezes everything else.
   always_comb begin
      w_state_nx    = r_state;
      w_fetch_pc_nx = r_fetch_pc;
      if (redirect_en) begin
         w_fetch_pc_nx = redirect_pc + 1'b1;
         w_state_nx    = (redirect_pc == LAST) ? ST_LAST : ST_RUN;
      end else if (!stall) begin
         case (r_state)
            ST_RUN: begin
               if (r_fetch_pc == LAST) w_state_nx = ST_LAST;
               else                    w_fetch_pc_nx = r_fetch_pc + 1'b1;
            end
            ST_LAST:   w_state_nx = ST_HALTED;
            default:   w_state_nx = r_state;
         endcase
      end
   end

   always_comb begin
      imem_addr = r_fetch_pc;
      if (redirect_en)                imem_addr = redirect_pc;
      else if (stall)                 imem_addr = pc_d1;
      else if (r_state == ST_HALTED)  imem_addr = LAST;
   end

   assign fetch_pc = r_fetch_pc;
   assign state    = r_state;
endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: drives a synchronous-read instruction memory and presents
// each returned word to decode with its PC, a valid flag and a delivery count.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
   parameter int LAST_ADDR   = 1023,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic [ADDR_WIDTH-1:0]  imem_addr,
   input  logic [DATA_WIDTH-1:0]  imem_data,
   input  logic                   stall,
   input  logic                   redirect_en,
   input  logic [ADDR_WIDTH-1:0]  redirect_pc,
   output logic [DATA_WIDTH-1:0]  instr_out,
   output logic [ADDR_WIDTH-1:0]  instr_pc,
   output logic                   instr_valid,
   output logic                   halted,
   output logic [COUNT_WIDTH-1:0] instr_count
);
   logic [ADDR_WIDTH-1:0]  r_pc_d1;
   logic                   r_valid_d1;
   logic [COUNT_WIDTH-1:0] r_instr_count;
   logic [ADDR_WIDTH-1:0]  w_fetch_pc;
   fetch_state_e           w_state;
   logic                   w_instr_valid;

   fetch_pc_ctrl #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .LAST_ADDR  (LAST_ADDR)
   ) u_pc_ctrl (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .redirect_en (redirect_en),
      .redirect_pc (redirect_pc),
      .pc_d1       (r_pc_d1),
      .imem_addr   (imem_addr),
      .fetch_pc    (w_fetch_pc),
      .state       (w_state)
   );

   // pc_d1/valid_d1 track the address whose data the memory returns next cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc_d1    <= '0;
         r_valid_d1 <= 1'b0;
      end else if (redirect_en) begin
         r_pc_d1    <= redirect_pc;
         r_valid_d1 <= 1'b1;
      end else if (!stall) begin
         case (w_state)
            ST_RUN: begin
               r_pc_d1    <= w_fetch_pc;
               r_valid_d1 <= 1'b1;
            end
            ST_LAST:  r_valid_d1 <= 1'b0;
            default:  r_valid_d1 <= r_valid_d1;
         endcase
      end
   end

   assign w_instr_valid = r_valid_d1 & ~redirect_en & (w_state != ST_HALTED);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_instr_count <= '0;
      else if (w_instr_valid && !stall && (r_instr_count != '1))
         r_instr_count <= r_instr_count + 1'b1;
   end

   assign instr_out   = imem_data;
   assign instr_pc    = r_pc_d1;
   assign instr_valid = w_instr_valid;
   assign halted      = (w_state == ST_HALTED);
   assign instr_count = r_instr_count;
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a small synchronous-read memory.
module tb_instruction_fetch;
   localparam int AW = 10;
   localparam int DW = 32;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] imem_addr;
   logic [DW-1:0] imem_data;
   logic          stall;
   logic          redirect_en;
   logic [AW-1:0] redirect_pc;
   logic [DW-1:0] instr_out;
   logic [AW-1:0] instr_pc;
   logic          instr_valid;
   logic          halted;
   logic [CW-1:0] instr_count;

   int checks   = 0;
   int failures = 0;
   int n35;

   instruction_fetch #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .LAST_ADDR  (35),
      .COUNT_WIDTH(CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_addr   (imem_addr),
      .imem_data   (imem_data),
      .stall       (stall),
      .redirect_en (redirect_en),
      .redirect_pc (redirect_pc),
      .instr_out   (instr_out),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .halted      (halted),
      .instr_count (instr_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
      case (a)
         10'd3, 10'd15: return 32'h15E00D40;
         10'd7:         return 32'h10202A22;
         default:       return 32'hC000_0000 | {22'd0, a};
      endcase
   endfunction

   always @(posedge clk) imem_data <= mem_word(imem_addr);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Runs until halted or the cycle budget expires; counts PC 35 deliveries.
   task automatic run_to_halt;
      n35 = 0;
      for (int i = 0; i < 80; i++) begin
         tick;
         #2;
         if (instr_valid && instr_pc == 10'd35) n35++;
         if (halted) break;
      end
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
      repeat (2) @(posedge clk);
      #3;
      chk("rst_addr",  32'(imem_addr), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_pc",    32'(instr_pc), 32'd0);
      chk("rst_halt",  32'(halted), 32'd0);
      chk("rst_cnt",   32'(instr_count), 32'd0);
      rst = 1'b0;
      #1;
      chk("c0_addr", 32'(imem_addr), 32'd0);

      // Sequential fetch: addr k, PC k-1 valid
      for (int k = 1; k <= 8; k++) begin
         tick; #2;
         chk("seq_valid", 32'(instr_valid), 32'd1);
         chk("seq_pc",    32'(instr_pc), 32'(k - 1));
         chk("seq_addr",  32'(imem_addr), 32'(k));
         if (k == 4) chk("pc3_data", instr_out, 32'h15E00D40);
      end
      chk("cnt_pc7", 32'(instr_count), 32'd7);

      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #0;
         chk("stall_pc",   32'(instr_pc), 32'd7);
         chk("stall_data", instr_out, 32'h10202A22);
         chk("stall_addr", 32'(imem_addr), 32'd7);
         tick; #2;
      end
      stall = 1'b0;
      #1;
      chk("post_stall_pc",  32'(instr_pc), 32'd7);
      chk("post_stall_cnt", 32'(instr_count), 32'd7);
      tick; #2;
      chk("pc8_pc",  32'(instr_pc), 32'd8);
      chk("pc8_cnt", 32'(instr_count), 32'd8);
      tick; tick; #2;
      chk("pc10_pc", 32'(instr_pc), 32'd10);

      redirect_en = 1'b1; redirect_pc = 10'd15;
      #1;
      chk("redir_valid", 32'(instr_valid), 32'd0);
      chk("redir_addr",  32'(imem_addr), 32'd15);
      chk("redir_cnt",   32'(instr_count), 32'd10);
      tick;
      redirect_en = 1'b0;
      #2;
      chk("tgt_pc",    32'(instr_pc), 32'd15);
      chk("tgt_data",  instr_out, 32'h15E00D40);
      chk("tgt_valid", 32'(instr_valid), 32'd1);
      chk("tgt_cnt",   32'(instr_count), 32'd10);

      run_to_halt;
      chk("halt1_reached", 32'(halted), 32'd1);
      chk("halt1_valid",   32'(instr_valid), 32'd0);
      chk("halt1_addr",    32'(imem_addr), 32'd35);
      chk("halt1_n35",     32'(n35), 32'd1);
      chk("halt1_cnt",     32'(instr_count), 32'd31);
      tick; #2;
      chk("halt1_hold_addr", 32'(imem_addr), 32'd35);
      chk("halt1_hold_cnt",  32'(instr_count), 32'd31);

      redirect_en = 1'b1; redirect_pc = 10'd0;
      #1;
      chk("hredir_addr",  32'(imem_addr), 32'd0);
      chk("hredir_valid", 32'(instr_valid), 32'd0);
      tick;
      redirect_en = 1'b0;
      #2;
      chk("hredir_halt",  32'(halted), 32'd0);
      chk("hredir_pc",    32'(instr_pc), 32'd0);
      chk("hredir_vld",   32'(instr_valid), 32'd1);

      for (int k = 1; k <= 20; k++) tick;
      #2;
      chk("pc20_pc", 32'(instr_pc), 32'd20);
      stall = 1'b1;
      tick; #2;
      rst = 1'b1;
      #1;
      chk("arst_valid", 32'(instr_valid), 32'd0);
      chk("arst_pc",    32'(instr_pc), 32'd0);
      chk("arst_halt",  32'(halted), 32'd0);
      chk("arst_addr",  32'(imem_addr), 32'd0);
      chk("arst_cnt",   32'(instr_count), 32'd0);
      tick; #2;
      rst = 1'b0; stall = 1'b0;
      tick; #2;
      chk("restart_pc",    32'(instr_pc), 32'd0);
      chk("restart_valid", 32'(instr_valid), 32'd1);

      run_to_halt;
      chk("halt2_reached", 32'(halted), 32'd1);
      chk("halt2_n35",     32'(n35), 32'd1);
      chk("halt2_cnt",     32'(instr_count), 32'd36);
      chk("halt2_addr",    32'(imem_addr), 32'd35);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
